// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and redirects on ID branches.
// Optional IF_PERF_CNT_EN adds fetch and redirect event counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int          STALL_W  = 6,
    parameter int          BR_W     = 33,
    parameter int          IF_ID_W  = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [BR_W-1:0]    br_bus,
    output logic [IF_ID_W-1:0] if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        br_pend;
    logic [31:0] br_pend_addr;
    logic [31:0] next_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        advance;
    logic        unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign advance      = ~stall[0];
    assign unused_stall = ^stall[STALL_W-1:1];

    // A live branch beats one parked while the stage was stalled.
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend) begin
            next_pc = br_pend_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            ce_reg       <= 1'b0;
            br_pend      <= 1'b0;
            br_pend_addr <= 32'b0;
        end else if (advance) begin
            pc_reg  <= next_pc;
            ce_reg  <= 1'b1;
            br_pend <= 1'b0;
        end else if (br_e) begin
            br_pend      <= 1'b1;
            br_pend_addr <= br_addr;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'b0;
            perf_redirect_cnt <= 32'b0;
        end else if (advance) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (br_e || br_pend) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

    assign if_to_id_bus    = {ce_reg, pc_reg};
    assign inst_sram_en    = ce_reg;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a queue of expected {ce, pc} values.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'b0;
    logic [32:0] br_bus = 33'b0;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .if_to_id_bus   (if_to_id_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    task automatic check(input string tag);
        logic [32:0]  e;
        logic [101:0] obs;
        logic [101:0] req;
        e   = exp_q.pop_front();
        obs = {if_to_id_bus, inst_sram_en, inst_sram_addr,
               inst_sram_wen, inst_sram_wdata};
        req = {e, e[32], e[31:0], 4'b0, 32'b0};
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: got ce=%b pc=%h en=%b addr=%h wen=%h wdata=%h, expected ce=%b pc=%h",
                   tag, if_to_id_bus[32], if_to_id_bus[31:0], inst_sram_en,
                   inst_sram_addr, inst_sram_wen, inst_sram_wdata, e[32], e[31:0]);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic be,
                        input logic [31:0] ba, input logic [31:0] exp_pc);
        stall  = {5'b0, s};
        br_bus = {be, ba};
        exp_q.push_back({1'b1, exp_pc});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    initial begin
        #3 rst = 1'b1;
        #1;
        exp_q.push_back({1'b0, 32'hBFBF_FFFC});
        check("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        step("seq0", 0, 0, 32'h0, 32'hBFC0_0000);
        step("seq1", 0, 0, 32'h0, 32'hBFC0_0004);
        step("seq2", 0, 0, 32'h0, 32'hBFC0_0008);
        step("seq3", 0, 0, 32'h0, 32'hBFC0_000C);
        step("seq4", 0, 0, 32'h0, 32'hBFC0_0010);

        step("br_taken", 0, 1, 32'hBFC0_0100, 32'hBFC0_0100);
        step("br_next", 0, 0, 32'hDEAD_BEEF, 32'hBFC0_0104);
        step("br_to20", 0, 1, 32'hBFC0_0020, 32'hBFC0_0020);

        step("stall1_br", 1, 1, 32'hBFC0_0200, 32'hBFC0_0020);
        step("stall2", 1, 0, 32'h0, 32'hBFC0_0020);
        step("stall3", 1, 0, 32'h0, 32'hBFC0_0020);
        step("pend_release", 0, 0, 32'h0, 32'hBFC0_0200);
        step("pend_cleared", 0, 0, 32'h0, 32'hBFC0_0204);

        step("two_br_a", 1, 1, 32'h0000_1000, 32'hBFC0_0204);
        step("two_br_b", 1, 1, 32'h0000_2000, 32'hBFC0_0204);
        step("two_br_rel", 0, 0, 32'h0, 32'h0000_2000);
        step("two_br_next", 0, 0, 32'h0, 32'h0000_2004);

        step("live_pend", 1, 1, 32'h0000_5000, 32'h0000_2004);
        step("live_wins", 0, 1, 32'h0000_3000, 32'h0000_3000);
        step("live_next", 0, 0, 32'h0, 32'h0000_3004);

        step("to_top", 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 32'h0, 32'h0000_0000);
        step("wrap_next", 0, 0, 32'h0, 32'h0000_0004);

        step("abort_pend", 1, 1, 32'h0000_ABC0, 32'h0000_0004);
        #2 rst = 1'b1;
        stall  = 6'b0;
        br_bus = 33'b0;
        #1;
        exp_q.push_back({1'b0, 32'hBFBF_FFFC});
        check("reset_abort");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step("restart_seq", 0, 0, 32'h0, 32'hBFC0_0000 + 32'(i) * 32'd4);
        end
        step("redir_a", 0, 1, 32'hBFC0_0400, 32'hBFC0_0400);
        step("redir_b", 0, 1, 32'hBFC0_0800, 32'hBFC0_0800);

`ifdef IF_PERF_CNT_EN
        check_val("perf_fetch", perf_fetch_cnt, 32'd12);
        check_val("perf_redirect", perf_redirect_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
